// File: rtl/data_receiver.sv
// Serial receive endpoint: hunts serial_in for SYNC_WORD, then shifts in one ENC_DATA_BITS payload MSB first.
// Define DATA_RECEIVER_TIMEOUT_EN to abandon a hunt after SYNC_TIMEOUT cycles without a match.
module data_receiver #(
  parameter int                   ENC_DATA_BITS = 216,
  parameter int                   SYNC_BITS     = 8,
  parameter logic [SYNC_BITS-1:0] SYNC_WORD     = 8'hF0,
  parameter int                   SYNC_TIMEOUT  = 1024
) (
  input  logic                     clk,
  input  logic                     rst_l,
  input  logic                     receive_start,
  input  logic                     serial_in,
  output logic                     receive_done,
  output logic [ENC_DATA_BITS-1:0] data_out
);

  // state   | meaning
  // IDLE    | waiting for receive_start; last result held on data_out/receive_done
  // SYNC    | hunting serial_in for SYNC_WORD
  // RECEIVE | shifting in payload bits, MSB first
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SYNC    = 2'd1,
    RECEIVE = 2'd2
  } state_t;

  localparam logic [7:0] LAST_BIT = 8'(ENC_DATA_BITS - 1);

  if (ENC_DATA_BITS < 2 || ENC_DATA_BITS > 255 || SYNC_BITS < 2 || SYNC_TIMEOUT < 1) begin : g_param_check
    $error("data_receiver: unsupported parameter combination");
  end

  state_t                   state;
  state_t                   state_next;
  logic                     sync_en;
  logic [SYNC_BITS-1:0]     sync_reg;
  logic [SYNC_BITS-1:0]     sync_reg_next;
  logic [SYNC_BITS-1:0]     sync_shift;
  logic                     sync_done;
  logic                     sync_done_next;
  logic [7:0]               receive_count;
  logic [7:0]               receive_count_next;
  logic                     receive_done_next;
  logic [ENC_DATA_BITS-1:0] data_out_next;
  logic [ENC_DATA_BITS-1:0] data_shift;

`ifdef DATA_RECEIVER_TIMEOUT_EN
  localparam int              HUNT_W    = $clog2(SYNC_TIMEOUT + 1);
  localparam logic [HUNT_W-1:0] HUNT_LOAD = HUNT_W'(SYNC_TIMEOUT - 1);

  logic [HUNT_W-1:0] hunt_count;
  logic [HUNT_W-1:0] hunt_count_next;
`endif

  assign sync_en    = (state == SYNC);
  assign sync_shift = (sync_reg << 1) | SYNC_BITS'(serial_in);
  assign data_shift = (data_out << 1) | ENC_DATA_BITS'(serial_in);

  always_comb begin
    state_next         = state;
    sync_reg_next      = sync_en ? sync_shift : sync_reg;
    sync_done_next     = sync_done;
    receive_count_next = receive_count;
    receive_done_next  = receive_done;
    data_out_next      = data_out;
`ifdef DATA_RECEIVER_TIMEOUT_EN
    hunt_count_next    = hunt_count;
`endif

    case (state)
      IDLE: begin
        if (receive_start) begin
          state_next         = SYNC;
          sync_reg_next      = '0;
          sync_done_next     = 1'b0;
          receive_count_next = '0;
          receive_done_next  = 1'b0;
          data_out_next      = '0;
`ifdef DATA_RECEIVER_TIMEOUT_EN
          hunt_count_next    = HUNT_LOAD;
`endif
        end
      end

      SYNC: begin
        // Compare against the shifted value so the match lands on the edge sampling the last sync bit.
        if (sync_shift == SYNC_WORD) begin
          state_next         = RECEIVE;
          sync_done_next     = 1'b1;
          receive_count_next = '0;
        end
`ifdef DATA_RECEIVER_TIMEOUT_EN
        else if (hunt_count == '0) begin
          state_next        = IDLE;
          sync_done_next    = 1'b0;
          receive_done_next = 1'b0;
        end else begin
          hunt_count_next = hunt_count - 1'b1;
        end
`endif
      end

      RECEIVE: begin
        data_out_next      = data_shift;
        receive_count_next = receive_count + 8'd1;
        if (sync_done && receive_count == LAST_BIT) begin
          receive_done_next = 1'b1;
          state_next        = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      sync_reg      <= '0;
      sync_done     <= 1'b0;
      receive_count <= '0;
      receive_done  <= 1'b0;
      data_out      <= '0;
`ifdef DATA_RECEIVER_TIMEOUT_EN
      hunt_count    <= '0;
`endif
    end else begin
      sync_reg      <= sync_reg_next;
      sync_done     <= sync_done_next;
      receive_count <= receive_count_next;
      receive_done  <= receive_done_next;
      data_out      <= data_out_next;
`ifdef DATA_RECEIVER_TIMEOUT_EN
      hunt_count    <= hunt_count_next;
`endif
    end
  end

endmodule

// File: tb/tb_data_receiver.sv
// Bench for data_receiver: bit-stream reference model predicts sync edge, done edge and payload.
// Build with DATA_RECEIVER_TIMEOUT_EN defined to exercise the hunt timeout.
module tb_data_receiver;
  localparam int          W         = 216;
  localparam logic [7:0]  SYNC      = 8'hF0;
  localparam logic [W-1:0] LOOP_DATA = {108{2'b10}};

  logic         clk;
  logic         rst_l;
  logic         receive_start;
  logic         serial_in;
  logic         receive_done;
  logic [W-1:0] data_out;

  int n_tests = 0;
  int n_fail  = 0;
  bit stim_q[$];

  data_receiver dut (
    .clk          (clk),
    .rst_l        (rst_l),
    .receive_start(receive_start),
    .serial_in    (serial_in),
    .receive_done (receive_done),
    .data_out     (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit bit_at(input int i);
    return (i < stim_q.size()) ? stim_q[i] : 1'b0;
  endfunction

  // Bit k of stim_q is sampled at edge E(k+1) after arming at E0; sync is the first 8-bit window equal to SYNC.
  function automatic void model(output int se, output int de, output logic [W-1:0] pl);
    logic [7:0] win;
    win = '0;
    se  = -1;
    de  = -1;
    pl  = '0;
    for (int k = 0; k < stim_q.size(); k++) begin
      win = {win[6:0], stim_q[k]};
      if (win == SYNC) begin
        se = k + 1;
        break;
      end
    end
    if (se >= 0) begin
      for (int j = 0; j < W; j++) pl[W-1-j] = bit_at(se + j);
      de = se + W;
    end
  endfunction

  task automatic push_bits(input logic [W-1:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) stim_q.push_back(v[i]);
  endtask

  function automatic logic [W-1:0] rand_payload();
    logic [W-1:0] p;
    for (int i = 0; i < W; i++) p[i] = 1'($urandom_range(0, 1));
    return p;
  endfunction

  task automatic run_frame(input string tag, input bit pre_armed, input int pulse_off, output int done_seen);
    int           se;
    int           de;
    logic [W-1:0] pl;
    model(se, de, pl);
    done_seen = -1;
    if (!pre_armed) begin
      @(negedge clk);
      receive_start = 1'b1;
      serial_in     = 1'b0;
    end
    @(negedge clk);
    receive_start = 1'b0;
    chk({tag, "_clr_done"}, receive_done, 0);
    chk({tag, "_clr_data"}, data_out, 0);
    chk({tag, "_sync_en"}, dut.sync_en, 1);
    for (int e = 1; e <= de + 3; e++) begin
      serial_in     = bit_at(e - 1);
      receive_start = (pulse_off > 0 && e == se + pulse_off);
      @(negedge clk);
      if (receive_done && done_seen < 0) done_seen = e;
      chk({tag, "_done"}, receive_done, (e >= de));
      chk({tag, "_sync_done"}, dut.sync_done, (e >= se));
    end
    receive_start = 1'b0;
    serial_in     = 1'b0;
    chk({tag, "_data"}, data_out, pl);
  endtask

  initial begin
    int ds;
    bit found;

    rst_l         = 1'b0;
    receive_start = 1'b1;
    serial_in     = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_done", receive_done, 0);
    chk("rst_data", data_out, 0);
    chk("rst_sync_en", dut.sync_en, 0);
    chk("rst_sync_done", dut.sync_done, 0);

    // Loopback as the sender would drive it: one idle bit, sync word, payload.
    stim_q.delete();
    push_bits('0, 1);
    push_bits(W'(SYNC), 8);
    push_bits(LOOP_DATA, W);
    rst_l = 1'b1;
    run_frame("loop", 1'b1, 0, ds);
    chk("loop_latency", ds, 225);

    // Noise made of 0F/33 fragments ahead of the sync word, all-ones payload.
    stim_q.delete();
    push_bits(W'(20'h0F330), 20);
    push_bits(W'(SYNC), 8);
    push_bits('1, W);
    run_frame("noise", 1'b0, 0, ds);
    chk("noise_payload", data_out, '1);

    // Start pulse mid-RECEIVE is ignored; the following start clears and re-arms.
    stim_q.delete();
    push_bits('0, 3);
    push_bits(W'(SYNC), 8);
    push_bits(rand_payload(), W);
    run_frame("pulse", 1'b0, 50, ds);
    stim_q.delete();
    push_bits('0, 2);
    push_bits(W'(SYNC), 8);
    push_bits(rand_payload(), W);
    run_frame("restart", 1'b0, 0, ds);

    for (int it = 0; it < 4; it++) begin
      stim_q.delete();
      push_bits('0, $urandom_range(0, 12));
      for (int n = $urandom_range(0, 24); n > 0; n--) stim_q.push_back(1'($urandom_range(0, 1)));
      push_bits(W'(SYNC), 8);
      push_bits(rand_payload(), W);
      push_bits('0, 4);
      run_frame("rand", 1'b0, (it % 2 == 1) ? 1 + $urandom_range(0, 150) : 0, ds);
    end

    // Reset when receive_count reaches 100.
    stim_q.delete();
    push_bits('0, 1);
    push_bits(W'(SYNC), 8);
    push_bits(rand_payload() | W'(1) << (W - 1), W);
    @(negedge clk);
    receive_start = 1'b1;
    @(negedge clk);
    receive_start = 1'b0;
    found = 1'b0;
    for (int e = 1; e < 400; e++) begin
      serial_in = bit_at(e - 1);
      @(negedge clk);
      if (dut.receive_count == 8'd100) begin
        found = 1'b1;
        break;
      end
    end
    chk("midrst_reached", found, 1);
    #1 rst_l = 1'b0;
    #1;
    chk("midrst_done", receive_done, 0);
    chk("midrst_data", data_out, 0);
    chk("midrst_sync_en", dut.sync_en, 0);
    chk("midrst_sync_done", dut.sync_done, 0);
    chk("midrst_count", dut.receive_count, 0);
    serial_in = 1'b0;
    @(negedge clk);
    rst_l = 1'b1;
    stim_q.delete();
    push_bits('0, 5);
    push_bits(W'(SYNC), 8);
    push_bits(rand_payload(), W);
    run_frame("after_rst", 1'b0, 0, ds);

    // Hunt with the line held at 0.
    @(negedge clk);
    receive_start = 1'b1;
    serial_in     = 1'b0;
    @(negedge clk);
    receive_start = 1'b0;
`ifdef DATA_RECEIVER_TIMEOUT_EN
    for (int e = 1; e <= 1024; e++) begin
      @(negedge clk);
      if (e == 1023) chk("to_still_sync", dut.sync_en, 1);
    end
    chk("to_idle", dut.sync_en, 0);
    chk("to_done", receive_done, 0);
    chk("to_sync_done", dut.sync_done, 0);
`else
    repeat (1100) @(negedge clk);
    chk("hunt_still_sync", dut.sync_en, 1);
    chk("hunt_done", receive_done, 0);
    chk("hunt_sync_done", dut.sync_done, 0);
`endif
    rst_l = 1'b0;
    @(negedge clk);
    chk("final_rst_sync_en", dut.sync_en, 0);
    rst_l = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
